// File: rtl/cache_arbiter_pkg.sv
// Shared types for the L1 I/D to L2 cache arbiter.
// Optional performance counters are enabled with the CACHE_ARB_PERF_EN macro.
package cache_arbiter_pkg;

    localparam int unsigned CACHE_LINE_WIDTH = 256;
    localparam int unsigned CACHE_ADDR_WIDTH = 32;
    localparam int unsigned CACHE_CNT_WIDTH  = 32;

    localparam logic ARB_GNT_I = 1'b0;
    localparam logic ARB_GNT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef logic [CACHE_LINE_WIDTH-1:0] cache_line_t;

    // Round-robin pick: D wins when it is the only requester or when I was granted last.
    function automatic logic arb_pick_d(input logic i_req, input logic d_req, input logic last_grant);
        return d_req && (!i_req || (last_grant == ARB_GNT_I));
    endfunction

endpackage

// File: rtl/arb_perf_counter.sv
// Saturating event counter with synchronous active-low reset.
// Used by cache_arbiter only when CACHE_ARB_PERF_EN is defined.
module arb_perf_counter #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter for I-cache and D-cache line traffic onto a single L2 port.
// Define CACHE_ARB_PERF_EN to build grant/contention counters; otherwise perf_* read 0.
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WIDTH = CACHE_LINE_WIDTH,
    parameter int unsigned ADDR_WIDTH = CACHE_ADDR_WIDTH,
    parameter int unsigned CNT_WIDTH  = CACHE_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic                  i_resp,
    output logic [LINE_WIDTH-1:0] i_rdata,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic                  d_resp,
    output logic [LINE_WIDTH-1:0] d_rdata,

    output logic                  m_read,
    output logic                  m_write,
    output logic [ADDR_WIDTH-1:0] m_address,
    output logic [LINE_WIDTH-1:0] m_wdata,
    input  logic                  m_resp,
    input  logic [LINE_WIDTH-1:0] m_rdata,

    output logic [CNT_WIDTH-1:0]  perf_i_grants,
    output logic [CNT_WIDTH-1:0]  perf_d_grants,
    output logic [CNT_WIDTH-1:0]  perf_conflict
);

    arb_state_t            state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  m_read_q, m_read_d;
    logic                  m_write_q, m_write_d;
    logic [ADDR_WIDTH-1:0] m_address_q, m_address_d;
    logic [LINE_WIDTH-1:0] m_wdata_q, m_wdata_d;

    logic i_req, d_req;
    logic grant_i, grant_d;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    assign grant_d = (state_q == IDLE) && arb_pick_d(i_req, d_req, last_grant_q);
    assign grant_i = (state_q == IDLE) && i_req && !grant_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_read_d     = m_read_q;
        m_write_d    = m_write_q;
        m_address_d  = m_address_q;
        m_wdata_d    = m_wdata_q;
        unique case (state_q)
            IDLE: begin
                // A write wins over a read raised on the same side.
                if (grant_d) begin
                    state_d      = SERVE_D;
                    last_grant_d = ARB_GNT_D;
                    m_write_d    = d_write;
                    m_read_d     = d_read & ~d_write;
                    m_address_d  = d_address;
                    m_wdata_d    = d_wdata;
                end else if (grant_i) begin
                    state_d      = SERVE_I;
                    last_grant_d = ARB_GNT_I;
                    m_write_d    = i_write;
                    m_read_d     = i_read & ~i_write;
                    m_address_d  = i_address;
                    m_wdata_d    = i_wdata;
                end
            end
            SERVE_I, SERVE_D: begin
                if (m_resp) begin
                    state_d   = IDLE;
                    m_read_d  = 1'b0;
                    m_write_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ARB_GNT_I;
            m_read_q     <= 1'b0;
            m_write_q    <= 1'b0;
            m_address_q  <= '0;
            m_wdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            m_read_q     <= m_read_d;
            m_write_q    <= m_write_d;
            m_address_q  <= m_address_d;
            m_wdata_q    <= m_wdata_d;
        end
    end

    assign m_read    = m_read_q;
    assign m_write   = m_write_q;
    assign m_address = m_address_q;
    assign m_wdata   = m_wdata_q;

    // Completion is forwarded combinationally so the requester sees it in the same cycle.
    assign i_resp  = (state_q == SERVE_I) && m_resp;
    assign d_resp  = (state_q == SERVE_D) && m_resp;
    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

`ifdef CACHE_ARB_PERF_EN
    logic conflict;

    // A cycle is contended when one side waits on the other, including a lost tie.
    assign conflict = ((state_q == SERVE_I) && d_req) ||
                      ((state_q == SERVE_D) && i_req) ||
                      ((state_q == IDLE) && i_req && d_req);

    arb_perf_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_perf_i_grants (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (grant_i),
        .count_o(perf_i_grants)
    );

    arb_perf_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_perf_d_grants (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (grant_d),
        .count_o(perf_d_grants)
    );

    arb_perf_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_perf_conflict (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .inc_i  (conflict),
        .count_o(perf_conflict)
    );
`else
    assign perf_i_grants = '0;
    assign perf_d_grants = '0;
    assign perf_conflict = '0;
`endif

    a_i_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == SERVE_I) |-> (i_read || i_write))
        else $error("i-side request dropped before its response");

    a_d_held: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == SERVE_D) |-> (d_read || d_write))
        else $error("d-side request dropped before its response");

    a_resp_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == IDLE) |-> !m_resp)
        else $error("downstream response while idle");

    a_i_rw: assert property (@(posedge clk) disable iff (!rst_n) !(i_read && i_write))
        else $error("i-side read and write raised together");

    a_d_rw: assert property (@(posedge clk) disable iff (!rst_n) !(d_read && d_write))
        else $error("d-side read and write raised together");

endmodule
